// File: rtl/rat_bist_pkg.sv
// rtl/rat_bist_pkg.sv - shared types, default constants and pattern function for the register-file BIST
package rat_bist_pkg;

   localparam int          DEF_NUM_REGS = 32;
   localparam int          DEF_ADDR_W   = 5;
   localparam int          DEF_DATA_W   = 8;
   localparam logic [7:0]  DEF_SEED     = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_WRITE_INV,
      ST_READ_INV,
      ST_DONE
   } bist_state_t;

   // Test pattern for register i: i XOR seed, optionally inverted. Callers pass
   // zero-extended operands and truncate the result to their data width.
   function automatic logic [31:0] pattern(input logic [31:0] addr,
                                           input logic [31:0] seed,
                                           input logic        inv);
      logic [31:0] p;
      p = addr ^ seed;
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/reg_file_bist.sv
// rtl/reg_file_bist.sv - write/read-back self-test master for the RAT register file; optional inverted pass under REG_FILE_BIST_INV_PASS_EN
module reg_file_bist
   import rat_bist_pkg::*;
#(
   parameter int                NUM_REGS = DEF_NUM_REGS,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] SEED     = DATA_W'(DEF_SEED)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [ADDR_W-1:0] FAIL_ADDR,
   output logic [DATA_W-1:0] RF_DIN,
   output logic [ADDR_W-1:0] RF_ADRX,
   output logic [ADDR_W-1:0] RF_ADRY,
   output logic              RF_WR,
   input  logic [DATA_W-1:0] RF_DX,
   input  logic [DATA_W-1:0] RF_DY
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   bist_state_t       state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic              pass_r, pass_n;
   logic [ADDR_W-1:0] fail_r, fail_n;

   logic              inv_phase;
   logic              is_write;
   logic              is_read;
   logic [ADDR_W-1:0] addr_y;
   logic [DATA_W-1:0] exp_x;
   logic [DATA_W-1:0] exp_y;
   logic              x_bad;
   logic              y_bad;
   logic [ADDR_W-1:0] rd_fail_addr;

   // Phase decode, expected data and the two same-cycle read comparators.
   always_comb begin
`ifdef REG_FILE_BIST_INV_PASS_EN
      inv_phase = (state == ST_WRITE_INV) || (state == ST_READ_INV);
      is_write  = (state == ST_WRITE) || (state == ST_WRITE_INV);
      is_read   = (state == ST_READ) || (state == ST_READ_INV);
`else
      inv_phase = 1'b0;
      is_write  = (state == ST_WRITE);
      is_read   = (state == ST_READ);
`endif
      addr_y       = LAST - addr;
      exp_x        = DATA_W'(pattern(32'(addr), 32'(SEED), inv_phase));
      exp_y        = DATA_W'(pattern(32'(addr_y), 32'(SEED), inv_phase));
      x_bad        = is_read && (RF_DX != exp_x);
      y_bad        = is_read && (RF_DY != exp_y);
      // X port wins when both ports miscompare in the same cycle.
      rd_fail_addr = x_bad ? addr : addr_y;
   end

   // Next-state, address counter and result capture.
   always_comb begin
      state_n = state;
      addr_n  = addr;
      pass_n  = pass_r;
      fail_n  = fail_r;
      case (state)
         ST_IDLE: begin
            if (START) begin
               state_n = ST_WRITE;
               addr_n  = '0;
            end
         end
         ST_WRITE: begin
            addr_n = addr + 1'b1;
            if (addr == LAST) begin
               state_n = ST_READ;
               addr_n  = '0;
            end
         end
         ST_READ: begin
            addr_n = addr + 1'b1;
            if (x_bad || y_bad) begin
               state_n = ST_DONE;
               addr_n  = '0;
               pass_n  = 1'b0;
               fail_n  = rd_fail_addr;
            end else if (addr == LAST) begin
               addr_n = '0;
`ifdef REG_FILE_BIST_INV_PASS_EN
               state_n = ST_WRITE_INV;
`else
               state_n = ST_DONE;
               pass_n  = 1'b1;
               fail_n  = '0;
`endif
            end
         end
`ifdef REG_FILE_BIST_INV_PASS_EN
         ST_WRITE_INV: begin
            addr_n = addr + 1'b1;
            if (addr == LAST) begin
               state_n = ST_READ_INV;
               addr_n  = '0;
            end
         end
         ST_READ_INV: begin
            addr_n = addr + 1'b1;
            if (x_bad || y_bad) begin
               state_n = ST_DONE;
               addr_n  = '0;
               pass_n  = 1'b0;
               fail_n  = rd_fail_addr;
            end else if (addr == LAST) begin
               state_n = ST_DONE;
               addr_n  = '0;
               pass_n  = 1'b1;
               fail_n  = '0;
            end
         end
`endif
         ST_DONE: begin
            if (START) begin
               state_n = ST_WRITE;
               addr_n  = '0;
               pass_n  = 1'b0;
               fail_n  = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            addr_n  = '0;
         end
      endcase
   end

   // State, address and result registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         addr   <= '0;
         pass_r <= 1'b0;
         fail_r <= '0;
      end else begin
         state  <= state_n;
         addr   <= addr_n;
         pass_r <= pass_n;
         fail_r <= fail_n;
      end
   end

   // Port outputs decode straight from state/addr so a reset edge drops RF_WR at once.
   always_comb begin
      BUSY      = is_write || is_read;
      DONE      = (state == ST_DONE);
      PASS      = pass_r;
      FAIL_ADDR = fail_r;
      RF_WR     = is_write;
      RF_DIN    = is_write ? exp_x : '0;
      RF_ADRX   = (is_write || is_read) ? addr : '0;
      RF_ADRY   = is_read ? addr_y : '0;
   end

endmodule

// File: tb/tb_reg_file_bist.sv
// tb/tb_reg_file_bist.sv - scoreboard bench for reg_file_bist with a fault-injectable register-file model
module tb_reg_file_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy, done, pass;
   logic [4:0] fail_addr;
   logic [7:0] rf_din;
   logic [4:0] rf_adrx, rf_adry;
   logic       rf_wr;
   logic [7:0] rf_dx, rf_dy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

`ifdef REG_FILE_BIST_INV_PASS_EN
   localparam int GOOD_CYC = 129;
`else
   localparam int GOOD_CYC = 65;
`endif

   reg_file_bist dut (
      .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done), .PASS(pass),
      .FAIL_ADDR(fail_addr), .RF_DIN(rf_din), .RF_ADRX(rf_adrx), .RF_ADRY(rf_adry),
      .RF_WR(rf_wr), .RF_DX(rf_dx), .RF_DY(rf_dy)
   );

   always #5 clk = ~clk;

   // Register file model: synchronous write, asynchronous reads with per-path stuck-at masks.
   logic [7:0] mem [32];
   logic [7:0] s0x [32];
   logic [7:0] s1x [32];
   logic [7:0] s0y [32];
   logic [7:0] s1y [32];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rf_wr) mem[rf_adrx] <= rf_din;
   end

   assign rf_dx = (mem[rf_adrx] & ~s0x[rf_adrx]) | s1x[rf_adrx];
   assign rf_dy = (mem[rf_adry] & ~s0y[rf_adry]) | s1y[rf_adry];

   typedef struct {
      logic pass;
      int   fa;
      int   cyc;
      int   start_cyc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < 32; i++) begin
         s0x[i] = 8'h00; s1x[i] = 8'h00; s0y[i] = 8'h00; s1y[i] = 8'h00;
      end
   endtask

   task automatic set_fault(input int a, input logic [7:0] m0, input logic [7:0] m1,
                            input logic xen, input logic yen);
      if (xen) begin s0x[a] = m0; s1x[a] = m1; end
      if (yen) begin s0y[a] = m0; s1y[a] = m1; end
   endtask

   // Pulses START for one edge; when exp_it is set the expected completion is queued.
   task automatic do_start(input logic exp_it, input logic e_pass, input int e_fa, input int e_cyc);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      if (exp_it) begin
         e.pass = e_pass; e.fa = e_fa; e.cyc = e_cyc; e.start_cyc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin seen = 1; break; end
         @(negedge clk);
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
      @(negedge clk);
   endtask

   task automatic wait_write(input int a, output bit ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rf_wr && rf_adrx == 5'(a)) begin ok = 1; break; end
      end
   endtask

   // Monitor: at each DONE rising edge pop the oldest expectation and compare.
   logic done_prev = 0, busy_prev = 0;
   int   busy_cnt  = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         done_prev = 0; busy_prev = 0; busy_cnt = 0;
      end else begin
         if (busy) busy_cnt = busy_prev ? busy_cnt + 1 : 1;
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("pass", int'(pass), int'(e.pass));
               check("fail_addr", int'(fail_addr), e.fa);
               check("done_cycle", cyc - e.start_cyc, e.cyc);
               check("busy_cycles", busy_cnt, e.cyc - 1);
            end
         end
         done_prev = done;
         busy_prev = busy;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      clear_faults();
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_fail_addr", int'(fail_addr), 0);
      check("rst_din", int'(rf_din), 0);
      check("rst_adrx", int'(rf_adrx), 0);
      check("rst_adry", int'(rf_adry), 0);
      check("rst_wr", int'(rf_wr), 0);
      rst = 1'b0;
      @(negedge clk);

      // Good file; register 7 receives 7 ^ A5 = A2.
      do_start(1, 1'b1, 0, GOOD_CYC);
      wait_write(7, ok);
      check("w7_seen", int'(ok), 1);
      check("w7_din", int'(rf_din), 8'hA2);
      check("w7_busy", int'(busy), 1);
      wait_done("good");

      // Reg 4 bit 0 stuck at 0 (P=A1): X read at addr 4, done at cycle 38.
      set_fault(4, 8'h01, 8'h00, 1, 1);
      do_start(1, 1'b0, 4, 38);
      wait_done("r4_s0");
      clear_faults();

      // Y-only fault on reg 27 (P=BE, bit 2 stuck 0): seen at READ addr 4.
      set_fault(27, 8'h04, 8'h00, 0, 1);
      do_start(1, 1'b0, 27, 38);
      wait_done("r27_y");
      clear_faults();

      // START in DONE clears the result and starts a fresh good run.
      do_start(1, 1'b1, 0, GOOD_CYC);
      check("restart_done", int'(done), 0);
      check("restart_busy", int'(busy), 1);
      check("restart_fail_addr", int'(fail_addr), 0);
      wait_done("restart");

      // X (reg 4) and Y (reg 27) fail in the same cycle: X wins.
      set_fault(4, 8'h01, 8'h00, 1, 0);
      set_fault(27, 8'h04, 8'h00, 0, 1);
      do_start(1, 1'b0, 4, 38);
      wait_done("prio");
      clear_faults();

      // Reg 31 Y path (P=BA, bit 0 stuck 1): first READ cycle.
      set_fault(31, 8'h00, 8'h01, 0, 1);
      do_start(1, 1'b0, 31, 34);
      wait_done("r31_y");
      clear_faults();

      // Reg 0 X path (P=A5, bit 7 stuck 0): first READ cycle, FAIL_ADDR 0.
      set_fault(0, 8'h80, 8'h00, 1, 0);
      do_start(1, 1'b0, 0, 34);
      wait_done("r0_x");
      clear_faults();

      // Reg 4 bit 3 stuck at 1 (P=A1 bit 3 is 0): caught in the first pass.
      set_fault(4, 8'h00, 8'h08, 1, 1);
      do_start(1, 1'b0, 4, 38);
      wait_done("r4_s1");
      clear_faults();

      // Reg 2 bit 5 stuck at 1 (P=A7 bit 5 is 1): only the inverted pass sees it.
      set_fault(2, 8'h00, 8'h20, 1, 1);
`ifdef REG_FILE_BIST_INV_PASS_EN
      do_start(1, 1'b0, 2, 100);
`else
      do_start(1, 1'b1, 0, 65);
`endif
      wait_done("r2_s1");
      clear_faults();

      // Reset during WRITE at addr 10, then a clean restart.
      do_start(0, 1'b0, 0, 0);
      wait_write(10, ok);
      check("w10_seen", int'(ok), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_wr", int'(rf_wr), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_adrx", int'(rf_adrx), 0);
      check("mid_rst_din", int'(rf_din), 0);
      rst = 1'b0;
      @(negedge clk);
      do_start(1, 1'b1, 0, GOOD_CYC);
      check("after_rst_adrx", int'(rf_adrx), 0);
      check("after_rst_wr", int'(rf_wr), 1);
      wait_done("after_rst");

      // START pulsed mid-run is ignored; completion timing is unchanged.
      do_start(1, 1'b1, 0, GOOD_CYC);
      repeat (18) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_bist.md
Name: reg_file_bist

Overview:
- Built-in self-test master for the 32x8 RAT register file. It drives the register-file write/read port: DIN, ADRX, ADRY and RF_WR.
- It writes a deterministic pattern into every register, then reads the pattern back through both asynchronous read ports (DX, DY) and compares it.
- It reports pass/fail and the first failing address. It sits beside REG_FILE and is muxed onto its port during power-on/debug test.

Parameters:
- NUM_REGS, 32, number of registers tested (power of two).
- ADDR_W, 5, register address width, equal to log2(NUM_REGS).
- DATA_W, 8, register data width.
- SEED, 8'hA5, XOR seed for the pattern P(i) = i[DATA_W-1:0] ^ SEED.

Ports:
- CLK  in  1  system clock; everything is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  single-cycle request to begin a test run.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  high from run completion until the next accepted START or RST.
- PASS  out  1  valid while DONE; 1 means no mismatch was found.
- FAIL_ADDR  out  ADDR_W  first mismatching register address; valid while DONE and !PASS.
- RF_DIN  out  DATA_W  write data to the register file.
- RF_ADRX  out  ADDR_W  X address (write and X read).
- RF_ADRY  out  ADDR_W  Y read address.
- RF_WR  out  1  register-file write enable (the file writes synchronously).
- RF_DX  in  DATA_W  asynchronous read data for RF_ADRX.
- RF_DY  in  DATA_W  asynchronous read data for RF_ADRY.

Behaviour:
- Reset: one clock and a synchronous, active-high reset; the clock port is CLK and the reset port is RST.
- While RST is high at an edge: state=IDLE, addr=0; BUSY, DONE, PASS, FAIL_ADDR, RF_DIN, RF_ADRX, RF_ADRY and RF_WR all 0.
- Port outputs are combinational from state/addr. As a result, RF_WR is 0 in the cycle after a reset edge, including reset in the middle of a run.
- IDLE:
  - START=1 moves to WRITE with addr=0; BUSY rises the next cycle.
- WRITE (one register per cycle):
  - RF_WR=1, RF_ADRX=addr, RF_DIN=P(addr), RF_ADRY=0.
  - addr increments each cycle.
  - At addr=NUM_REGS-1 the next state is READ with addr=0 (wrap, no overflow).
- READ (one pair per cycle):
  - RF_WR=0, RF_ADRX=addr, RF_ADRY=NUM_REGS-1-addr.
  - Same-cycle compare: RF_DX against P(addr), and RF_DY against P(NUM_REGS-1-addr).
  - On the first mismatch: go to DONE with PASS=0. FAIL_ADDR=addr if the DX compare failed, otherwise NUM_REGS-1-addr. X has priority when both fail.
  - With no mismatch through addr=NUM_REGS-1: go to DONE with PASS=1 and FAIL_ADDR=0.
- DONE:
  - BUSY=0, DONE=1; PASS and FAIL_ADDR hold.
  - START=1 clears DONE, PASS and FAIL_ADDR and enters WRITE with addr=0.
- START while BUSY is ignored.
- Latency for a good file: START accepted at edge 0, WRITE for cycles 1..NUM_REGS, READ for the next NUM_REGS cycles, DONE high at cycle 2*NUM_REGS+1 (65 with defaults).
- Arithmetic: addr is ADDR_W bits unsigned. P() truncates or zero-extends i to DATA_W before the XOR.

Optional Feature:
- Macro REG_FILE_BIST_INV_PASS_EN.
- Defined: after a clean READ, run a second WRITE_INV/READ_INV pass using ~P(i).
  - A mismatch in this pass is reported with the same FAIL_ADDR rule.
  - A good file reaches DONE at cycle 4*NUM_REGS+1 (129 with defaults).
  - Every data bit of every register is exercised in both polarities.
- Undefined: single pass only. The WRITE_INV and READ_INV states and the extra logic do not exist.

Decomposition:
- Package rat_bist_pkg:
  - state enum (IDLE, WRITE, READ, WRITE_INV, READ_INV, DONE);
  - default constants NUM_REGS/ADDR_W/DATA_W/SEED;
  - function pattern(addr, inv) returning P or ~P.
- No sub-module: the FSM, address counter and comparators form one flat block.

Test Plan:
- Good register-file model, START pulse -> BUSY for 64 cycles, DONE=1 and PASS=1 at cycle 65; register 7 holds 8'hA2 during WRITE.
- Model with reg 7 bit 0 stuck at 0 (P(7)=8'hA2 is even, so no fault; use reg 4, P=8'hA1) -> DONE=1, PASS=0, FAIL_ADDR=4.
- Fault only on the Y path at reg 27 -> FAIL_ADDR=27, detected at READ addr=4 (cycle 37).
- RST asserted at WRITE addr=10 -> next cycle RF_WR=0, BUSY=0, DONE=0; a fresh START restarts at addr 0.
- START pulsed again at cycle 20 of a run -> ignored, DONE still at cycle 65. START in DONE -> DONE clears, new run completes.
- With REG_FILE_BIST_INV_PASS_EN, reg 4 bit 3 stuck at 1 (P=8'hA1 has bit 3=0) -> caught in pass 1. Reg 2 bit 5 stuck at 1 (P=8'hA7 has bit 5=1) -> caught only in READ_INV, FAIL_ADDR=2; good file -> DONE at cycle 129.
